// File: rtl/io_port_bridge_pkg.sv
// Shared constants and the read-address decode for the CPU-to-UART I/O bridge.
package io_port_bridge_pkg;

  localparam logic [1:0]  IO_SEL     = 2'b11;
  localparam logic [17:0] ADDR_UART  = 18'h30000;
  localparam logic [17:0] ADDR_CLK   = 18'h30004;
  localparam logic [17:0] ADDR_SNAP1 = 18'h30005;
  localparam logic [17:0] ADDR_SNAP2 = 18'h30006;
  localparam logic [17:0] ADDR_SNAP3 = 18'h30007;

  localparam int TX_DEPTH_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    RD_NONE,
    RD_UART,
    RD_SNAP0,
    RD_SNAP1,
    RD_SNAP2,
    RD_SNAP3,
    RD_OTHER
  } rd_sel_e;

  // Maps an I/O address to the source that feeds io_din on the following cycle.
  function automatic rd_sel_e decode_read(input logic [17:0] addr);
    rd_sel_e sel;
    case (addr)
      ADDR_UART:  sel = RD_UART;
      ADDR_CLK:   sel = RD_SNAP0;
      ADDR_SNAP1: sel = RD_SNAP1;
      ADDR_SNAP2: sel = RD_SNAP2;
      ADDR_SNAP3: sel = RD_SNAP3;
      default:    sel = RD_OTHER;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Synchronous byte FIFO buffering CPU writes toward the UART transmitter.
module io_tx_fifo
  import io_port_bridge_pkg::*;
#(
  parameter int AW = TX_DEPTH_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [7:0]  data_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o,
  output logic [7:0]  head_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == DEPTH_W);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/io_port_bridge.sv
// Memory-mapped I/O bridge: CPU writes feed a TX FIFO toward the UART, reads return
// UART RX bytes or a snapshot of the free-running cycle counter.
module io_port_bridge
  import io_port_bridge_pkg::*;
#(
  parameter int          TX_DEPTH_WIDTH = TX_DEPTH_WIDTH_DEF,
  parameter int          FULL_MARGIN    = 1,
  // Value loaded into the cycle counter on reset; zero in normal use.
  parameter logic [31:0] CYC_CNT_RESET  = 32'h0
) (
  input  logic        Sys_clk,
  input  logic        Sys_rst,
  input  logic        Sys_rdy,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  io_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_finish,
  output logic        tx_overflow
);

  localparam int CW = TX_DEPTH_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_W  = CW'(1 << TX_DEPTH_WIDTH);
  localparam logic [CW-1:0] MARGIN_W = CW'(FULL_MARGIN);

  logic [17:0]   addr;
  logic          is_io;
  logic          wr_uart;
  logic          wr_clk;
  logic          push;
  logic [7:0]    push_data;
  logic          push_ok;
  logic          pop;
  rd_sel_e       rd_sel;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_nxt;

  logic [31:0]   cyc_cnt_q;
  logic [31:0]   snap_q,       snap_d;
  logic [7:0]    io_din_q,     io_din_d;
  logic          stop_q,       stop_d;
  logic          finish_q,     finish_d;
  logic          overflow_q,   overflow_d;
  logic          buf_full_q,   buf_full_d;

  logic          unused_addr_hi;
  assign unused_addr_hi = ^mem_a[31:18];

  assign addr  = mem_a[17:0];
  assign is_io = (addr[17:16] == IO_SEL);

  assign wr_uart   = Sys_rdy && is_io && mem_wr && (addr == ADDR_UART) && (mem_dout != 8'h00);
  assign wr_clk    = Sys_rdy && is_io && mem_wr && (addr == ADDR_CLK);
  assign push      = wr_uart || wr_clk;
  assign push_data = wr_clk ? 8'h00 : mem_dout;
  assign push_ok   = push && !fifo_full;

  assign tx_valid = Sys_rdy && !fifo_empty;
  assign pop      = tx_valid && tx_ready;

  assign rd_sel = (Sys_rdy && is_io && !mem_wr) ? decode_read(addr) : RD_NONE;
  assign rx_pop = !Sys_rst && (rd_sel == RD_UART) && rx_valid;

  io_tx_fifo #(
    .AW (TX_DEPTH_WIDTH)
  ) u_tx_fifo (
    .clk     (Sys_clk),
    .rst     (Sys_rst),
    .push_i  (push_ok),
    .pop_i   (pop),
    .data_i  (push_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (tx_data)
  );

  // Occupancy after this cycle's push/pop; drives the registered nearly-full flag.
  assign count_nxt = fifo_count + CW'(push_ok) - CW'(pop);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    io_din_d = io_din_q;
    snap_d   = snap_q;
    case (rd_sel)
      RD_UART:  io_din_d = rx_valid ? rx_data : 8'h00;
      RD_SNAP0: begin
        snap_d   = cyc_cnt_q;
        io_din_d = cyc_cnt_q[7:0];
      end
      RD_SNAP1: io_din_d = snap_q[15:8];
      RD_SNAP2: io_din_d = snap_q[23:16];
      RD_SNAP3: io_din_d = snap_q[31:24];
      RD_OTHER: io_din_d = 8'h00;
      default:  io_din_d = io_din_q;
    endcase

    stop_d     = stop_q || wr_clk;
    overflow_d = overflow_q || (push && fifo_full);
    finish_d   = finish_q || (stop_d && (count_nxt == '0));
    buf_full_d = ((DEPTH_W - count_nxt) <= MARGIN_W);
  end

  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      cyc_cnt_q  <= CYC_CNT_RESET;
      snap_q     <= '0;
      io_din_q   <= 8'h00;
      stop_q     <= 1'b0;
      finish_q   <= 1'b0;
      overflow_q <= 1'b0;
      buf_full_q <= 1'b0;
    end else begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
      // The counter keeps running while the CPU side is stalled; everything else freezes.
      if (Sys_rdy) begin
        snap_q     <= snap_d;
        io_din_q   <= io_din_d;
        stop_q     <= stop_d;
        finish_q   <= finish_d;
        overflow_q <= overflow_d;
        buf_full_q <= buf_full_d;
      end
    end
  end

  assign io_din         = io_din_q;
  assign io_buffer_full = buf_full_q;
  assign program_finish = finish_q;
  assign tx_overflow    = overflow_q;

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed self-checking bench for io_port_bridge with hand-computed expectations.
module tb_io_port_bridge;
  import io_port_bridge_pkg::*;

  localparam logic [31:0] CNT_INIT = 32'h1234_5600;
  localparam logic [31:0] A_UART   = 32'h0003_0000;
  localparam logic [31:0] A_CLK    = 32'h0003_0004;

  logic        Sys_clk;
  logic        Sys_rst;
  logic        Sys_rdy;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  io_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_finish;
  logic        tx_overflow;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;
  logic [31:0] cnt_a;
  logic [7:0]  obs_a;
  logic [7:0]  txq [$];

  io_port_bridge #(
    .TX_DEPTH_WIDTH (4),
    .FULL_MARGIN    (1),
    .CYC_CNT_RESET  (CNT_INIT)
  ) dut (
    .Sys_clk        (Sys_clk),
    .Sys_rst        (Sys_rst),
    .Sys_rdy        (Sys_rdy),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .io_din         (io_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pop         (rx_pop),
    .program_finish (program_finish),
    .tx_overflow    (tx_overflow)
  );

  initial Sys_clk = 1'b0;
  always #5 Sys_clk = ~Sys_clk;

  // Inputs only change just after a rising edge, so the falling edge sees each cycle's settled handshake.
  always @(negedge Sys_clk) begin
    if (!Sys_rst && tx_valid && tx_ready) txq.push_back(tx_data);
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] q_at(input int i);
    return (i < txq.size()) ? txq[i] : 8'hxx;
  endfunction

  task automatic idle();
    mem_a    = 32'h0;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
  endtask

  // One clock: expected counter follows reset or increments, returns 1 time unit past the edge.
  task automatic cyc();
    logic r;
    r = Sys_rst;
    @(posedge Sys_clk);
    #1;
    exp_cnt = r ? CNT_INIT : exp_cnt + 32'd1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = 1'b1;
    mem_dout = d;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [31:0] a);
    mem_a  = a;
    mem_wr = 1'b0;
    cyc();
    idle();
  endtask

  initial begin
    Sys_rst  = 1'b1;
    Sys_rdy  = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    exp_cnt  = 32'h0;
    idle();
    run(2);

    check("rst_io_din", io_din, 8'h00);
    check("rst_buf_full", io_buffer_full, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_finish", program_finish, 1'b0);
    check("rst_overflow", tx_overflow, 1'b0);
    check("rst_rx_pop", rx_pop, 1'b0);
    Sys_rst = 1'b0;
    cyc();

    // Single byte then an ignored zero byte; upper address bits are don't-care.
    tx_ready = 1'b1;
    wr(32'hFFFF_0000, 8'h41);
    check("t1_tx_valid", tx_valid, 1'b1);
    check("t1_tx_data", tx_data, 8'h41);
    wr(A_UART, 8'h00);
    check("t1_drained", tx_valid, 1'b0);
    run(3);
    check("t1_xfer_count", txq.size(), 1);
    check("t1_xfer_data", q_at(0), 8'h41);
    txq.delete();

    // Fill to the margin, to full, then overflow.
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr(A_UART, 8'(i + 1));
      if (i == 13) check("t2_full_after14", io_buffer_full, 1'b0);
      if (i == 14) check("t2_full_after15", io_buffer_full, 1'b1);
      if (i == 15) check("t2_ovf_after16", tx_overflow, 1'b0);
    end
    check("t2_ovf_after17", tx_overflow, 1'b1);
    check("t2_full_after17", io_buffer_full, 1'b1);
    check("t2_head", tx_data, 8'h01);
    tx_ready = 1'b1;
    run(18);
    check("t2_xfer_count", txq.size(), 16);
    check("t2_first", q_at(0), 8'h01);
    check("t2_last", q_at(15), 8'h10);
    check("t2_full_cleared", io_buffer_full, 1'b0);
    check("t2_ovf_sticky", tx_overflow, 1'b1);
    txq.delete();

    // Non-I/O writes have no effect.
    tx_ready = 1'b0;
    wr(32'h0002_0000, 8'h55);
    wr(32'h0000_0000, 8'h66);
    check("t3_nonio_write", tx_valid, 1'b0);

    // RX reads, hold behaviour and unmapped I/O reads.
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    mem_a    = A_UART;
    mem_wr   = 1'b0;
    #1;
    check("t3_rx_pop_pulse", rx_pop, 1'b1);
    cyc();
    idle();
    #1;
    check("t3_rx_pop_gone", rx_pop, 1'b0);
    check("t3_rx_data", io_din, 8'h5A);
    run(2);
    check("t3_hold", io_din, 8'h5A);
    rd(32'h0001_0000);
    check("t3_nonio_read", io_din, 8'h5A);
    rx_valid = 1'b0;
    mem_a    = A_UART;
    mem_wr   = 1'b0;
    #1;
    check("t3_no_pop", rx_pop, 1'b0);
    cyc();
    idle();
    check("t3_rx_empty", io_din, 8'h00);
    rx_valid = 1'b1;
    rd(A_UART);
    check("t3_rx_again", io_din, 8'h5A);
    rd(32'h0003_0008);
    check("t3_other_io", io_din, 8'h00);
    rx_valid = 1'b0;

    // Stall with Sys_rdy low: no push, no transfer, counter keeps running.
    wr(A_UART, 8'hA1);
    wr(A_UART, 8'hA2);
    cnt_a = exp_cnt;
    rd(A_CLK);
    check("t4_snap_before", io_din, cnt_a[7:0]);
    obs_a    = io_din;
    Sys_rdy  = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_a    = A_UART;
      mem_wr   = 1'b1;
      mem_dout = 8'hC0 + 8'(i);
      #1;
      check("t4_stall_valid", tx_valid, 1'b0);
      cyc();
    end
    idle();
    check("t4_stall_io_din", io_din, cnt_a[7:0]);
    Sys_rdy  = 1'b1;
    tx_ready = 1'b0;
    cnt_a    = exp_cnt;
    rd(A_CLK);
    check("t4_snap_after", io_din, cnt_a[7:0]);
    check("t4_cnt_delta", 8'(io_din - obs_a), 8'd6);
    rd(32'h0003_0005);
    check("t4_snap_byte1", io_din, cnt_a[15:8]);
    tx_ready = 1'b1;
    run(4);
    check("t4_xfer_count", txq.size(), 2);
    check("t4_xfer0", q_at(0), 8'hA1);
    check("t4_xfer1", q_at(1), 8'hA2);
    txq.delete();

    // Fresh reset, then snapshot at 0x12345678 and read the bytes back-to-back.
    tx_ready = 1'b0;
    Sys_rst  = 1'b1;
    cyc();
    Sys_rst = 1'b0;
    check("t5_ovf_reset", tx_overflow, 1'b0);
    for (int i = 0; i < 200 && exp_cnt != 32'h1234_5678; i++) cyc();
    check("t5_reached_count", exp_cnt, 32'h1234_5678);
    mem_wr = 1'b0;
    mem_a  = A_CLK;
    cyc();
    check("t5_byte0", io_din, 8'h78);
    mem_a = 32'h0003_0005;
    cyc();
    check("t5_byte1", io_din, 8'h56);
    mem_a = 32'h0003_0006;
    cyc();
    check("t5_byte2", io_din, 8'h34);
    mem_a = 32'h0003_0007;
    cyc();
    check("t5_byte3", io_din, 8'h12);
    idle();

    // Stop request behind three queued bytes.
    wr(A_UART, 8'h01);
    wr(A_UART, 8'h02);
    wr(A_UART, 8'h03);
    wr(A_CLK, 8'hEE);
    check("t6_finish_low", program_finish, 1'b0);
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i < 4) begin
        check("t6_draining_valid", tx_valid, 1'b1);
        check("t6_draining_finish", program_finish, 1'b0);
      end else begin
        check("t6_empty_valid", tx_valid, 1'b0);
        check("t6_finish_rise", program_finish, 1'b1);
      end
    end
    run(3);
    check("t6_finish_sticky", program_finish, 1'b1);
    check("t6_xfer_count", txq.size(), 4);
    check("t6_xfer_first", q_at(0), 8'h01);
    check("t6_xfer_last", q_at(3), 8'h00);
    txq.delete();

    // Reset in the middle of a drain, with Sys_rdy low and a read pending.
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) wr(A_UART, 8'h80 + 8'(i));
    check("t7_ovf_set", tx_overflow, 1'b1);
    rx_valid = 1'b1;
    rx_data  = 8'h3C;
    rd(A_UART);
    check("t7_io_din_set", io_din, 8'h3C);
    tx_ready = 1'b1;
    run(2);
    Sys_rst = 1'b1;
    Sys_rdy = 1'b0;
    mem_a   = A_UART;
    mem_wr  = 1'b0;
    #1;
    check("t7_rx_pop_in_reset", rx_pop, 1'b0);
    cyc();
    idle();
    txq.delete();
    rx_valid = 1'b0;
    Sys_rst  = 1'b0;
    Sys_rdy  = 1'b1;
    #1;
    check("t7_io_din", io_din, 8'h00);
    check("t7_buf_full", io_buffer_full, 1'b0);
    check("t7_overflow", tx_overflow, 1'b0);
    check("t7_finish", program_finish, 1'b0);
    check("t7_tx_valid", tx_valid, 1'b0);
    run(5);
    check("t7_no_xfer", txq.size(), 0);
    rd(32'h0003_0005);
    check("t7_snap_cleared", io_din, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_bridge.md
IO_PORT_BRIDGE -- requirements
Module: io_port_bridge

Interface
REQ-001 Parameter TX_DEPTH_WIDTH, default 4, log2 of the TX FIFO depth (16 entries).
REQ-002 Parameter FULL_MARGIN, default 1, number of free TX slots at which io_buffer_full asserts.
REQ-003 Sys_clk  in  1  sole clock; all state updates on posedge.
REQ-004 Sys_rst  in  1  reset, synchronous, active-high.
REQ-005 Sys_rdy  in  1  when low, all state except cyc_cnt holds.
REQ-006 mem_a  in  32  CPU address bus; only [17:0] decoded.
REQ-007 mem_dout  in  8  CPU write data.
REQ-008 mem_wr  in  1  1 = write, 0 = read.
REQ-009 io_din  out  8  read data returned to the CPU, valid the cycle after the read.
REQ-010 io_buffer_full  out  1  TX nearly full; the CPU stalls I/O writes.
REQ-011 tx_data / tx_valid / tx_ready  out 8 / out 1 / in 1  UART TX stream; transfer when valid&&ready.
REQ-012 rx_data / rx_valid / rx_pop  in 8 / in 1 / out 1  UART RX byte; pop is a one-cycle pulse.
REQ-013 program_finish  out  1  sticky; the program has stopped and TX has drained.
REQ-014 tx_overflow  out  1  sticky; a write arrived while the TX FIFO was full.

Function
REQ-015 An access is I/O when mem_a[17:16]==2'b11; all other addresses are ignored and have no side effects.
REQ-016 A write to 0x30000 with nonzero data pushes mem_dout into the TX FIFO in the same cycle; data 0x00 is ignored.
REQ-017 A write to 0x30004 pushes 0x00 into the TX FIFO and sets stop_pending.
REQ-018 program_finish rises the first cycle in which stop_pending=1 and the TX FIFO is empty; it stays high until reset.
REQ-019 A read of 0x30000 drives io_din on the next cycle: rx_data if rx_valid was high at the read, else 0x00; rx_pop pulses in the read cycle only when rx_valid=1.
REQ-020 cyc_cnt is a 32-bit counter, +1 every cycle not in reset (independent of Sys_rdy), and wraps 0xFFFFFFFF->0.
REQ-021 A read of 0x30004 latches cyc_cnt into snap; the next cycle io_din = snap[7:0].
REQ-022 Reads of 0x30005, 0x30006 and 0x30007 return snap[15:8], snap[23:16] and snap[31:24] the next cycle without re-latching snap.
REQ-023 Any other I/O read address returns 0x00 the next cycle.
REQ-024 io_din holds its last value when no read occurs.
REQ-025 TX FIFO pointers wrap modulo depth.
REQ-026 io_buffer_full = (free slots <= FULL_MARGIN); it is registered from post-update count.
REQ-027 A push when the FIFO is full is dropped and sets tx_overflow; the pointers are unchanged.
REQ-028 Simultaneous push and pop in one cycle leaves count unchanged; a push into an empty FIFO may be popped no earlier than the next cycle.
REQ-029 tx_valid = FIFO not empty; tx_data = head entry, combinationally from the FIFO storage.
REQ-030 When Sys_rdy=0: no push, no pop of TX, no rx_pop, and io_din and snap hold; tx_valid is forced 0.

Reset
REQ-031 When Sys_rst=1 at the clock edge, the following outputs and state SHALL clear: FIFO pointers and count = 0, stop_pending = 0, program_finish = 0, tx_overflow = 0, io_buffer_full = 0, io_din = 0x00, snap = 0, cyc_cnt = 0, rx_pop = 0.
REQ-032 Reset asserted mid-drain discards all FIFO contents; no further tx_valid occurs until a new push.
REQ-033 Reset has priority over Sys_rdy.

Structure
REQ-034 The shared package holds the I/O constants IO_SEL = 2'b11, ADDR_UART = 18'h30000 and ADDR_CLK = 18'h30004, plus the FIFO depth width.
REQ-035 One sub-module, io_tx_fifo: a synchronous FIFO with push, pop, full, empty, count and head outputs; all other logic lives in io_port_bridge.

Verification
REQ-036 Write 0x41 then 0x00 to 0x30000 with tx_ready=1 -> exactly one tx transfer, carrying 0x41.
REQ-037 tx_ready=0; 15 writes -> io_buffer_full=1 after the 15th; 16th accepted; 17th dropped with tx_overflow=1 and count=16.
REQ-038 At cyc_cnt=0x12345678, read 0x30004..0x30007 on consecutive cycles -> io_din = 0x78, 0x56, 0x34, 0x12, even though cyc_cnt has advanced.
REQ-039 rx_valid=1 with rx_data=0x5A, read 0x30000 -> rx_pop pulses once, io_din=0x5A the next cycle; with rx_valid=0 -> io_din=0x00 and no pop.
REQ-040 Write 0x30004 with 3 bytes queued and tx_ready=1 -> 4 transfers, the last being 0x00; program_finish rises the cycle after the FIFO empties.
REQ-041 Sys_rdy=0 for 5 cycles during a write burst -> no push and no tx transfer, cyc_cnt advances by 5; Sys_rst mid-drain -> all outputs return to their reset values.
